// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - FSM states, default timing constants and frame layout for the DHT11 controller
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_SYNC_L,
        ST_SYNC_H,
        ST_DATA_L,
        ST_DATA_H,
        ST_CHECK
    } dht11_state_t;

    localparam int DEF_START_US   = 18000;
    localparam int DEF_TIMEOUT_US = 100;
    localparam int DEF_BIT1_US    = 40;

    localparam int FRAME_W  = 40;
    localparam int US_CNT_W = 15;

    // Byte positions inside the 40-bit frame, byte4 arrives first.
    localparam int BYTE_HUM_INT  = 4;
    localparam int BYTE_HUM_DEC  = 3;
    localparam int BYTE_TEMP_INT = 2;
    localparam int BYTE_TEMP_DEC = 1;
    localparam int BYTE_CHECKSUM = 0;

    function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] frame, input int idx);
        return 8'(frame >> (idx * 8));
    endfunction

    // Sensor checksum: low byte of the sum of the four data bytes.
    function automatic logic checksum_ok(input logic [FRAME_W-1:0] frame);
        logic [7:0] sum;
        sum = frame_byte(frame, BYTE_HUM_INT) + frame_byte(frame, BYTE_HUM_DEC)
            + frame_byte(frame, BYTE_TEMP_INT) + frame_byte(frame, BYTE_TEMP_DEC);
        return sum == frame_byte(frame, BYTE_CHECKSUM);
    endfunction

endpackage

// File: rtl/tick_gen_us.sv
// rtl/tick_gen_us.sv - free-running divider producing a one-cycle tick every DIV clocks
// Ports: clk, rst (sync, active-high), tick (one-cycle pulse)
module tick_gen_us #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dht11_controller.sv
// rtl/dht11_controller.sv - DHT11 single-wire reader; checksum test enabled by DHT11_CHECKSUM_EN
// Ports: clk, rst (sync, active-high), start, dht_io (open-drain line),
//        humid/temp (integer bytes of last accepted frame), done (pulse), busy, error
module dht11_controller
    import dht11_pkg::*;
#(
    parameter int SYS_CLK_HZ = 100_000_000,
    parameter int START_US   = DEF_START_US,
    parameter int TIMEOUT_US = DEF_TIMEOUT_US,
    parameter int BIT1_US    = DEF_BIT1_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    inout  wire        dht_io,
    output logic [7:0] humid,
    output logic [7:0] temp,
    output logic       done,
    output logic       busy,
    output logic       error
);

    localparam int TICK_DIV = SYS_CLK_HZ / 1_000_000;
    localparam logic [US_CNT_W-1:0] START_LIM   = US_CNT_W'(START_US);
    localparam logic [US_CNT_W-1:0] TIMEOUT_LIM = US_CNT_W'(TIMEOUT_US);
    localparam logic [US_CNT_W-1:0] BIT1_LIM    = US_CNT_W'(BIT1_US);
    localparam logic [US_CNT_W-1:0] US_MAX      = '1;
    localparam logic [5:0]          LAST_BIT    = 6'(FRAME_W - 1);

    logic tick;

    tick_gen_us #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Line input synchronizer plus one history stage for edge detection.
    // Reset to 1: a released line reads high through the pull-up.
    logic sync1, sync2, sync_prev;
    logic rise, fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= dht_io;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign rise = sync2 & ~sync_prev;
    assign fall = ~sync2 & sync_prev;

    dht11_state_t        state;
    logic                drive_low;
    logic [US_CNT_W-1:0] us_cnt;
    logic [US_CNT_W-1:0] us_restart;
    logic [5:0]          bit_cnt;
    logic [FRAME_W-1:0]  shift_reg;
    logic                edge_hit;
    logic                bit_val;
    logic                frame_ok;

    // A tick landing on the restart cycle belongs to the new interval, so an
    // N us phase always spans exactly N counted ticks.
    assign us_restart = {{(US_CNT_W-1){1'b0}}, tick};
    assign bit_val    = (us_cnt > BIT1_LIM);

    always_comb begin
        edge_hit = 1'b0;
        case (state)
            ST_WAIT, ST_SYNC_H, ST_DATA_H: edge_hit = fall;
            ST_SYNC_L, ST_DATA_L:          edge_hit = rise;
            default:                       edge_hit = 1'b0;
        endcase
    end

`ifdef DHT11_CHECKSUM_EN
    assign frame_ok = checksum_ok(shift_reg);
`else
    assign frame_ok = 1'b1;
`endif

    assign busy   = (state != ST_IDLE);
    assign dht_io = drive_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            drive_low <= 1'b0;
            us_cnt    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            humid     <= '0;
            temp      <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tick && us_cnt != US_MAX) begin
                us_cnt <= us_cnt + US_CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_START;
                        drive_low <= 1'b1;
                        error     <= 1'b0;
                        bit_cnt   <= '0;
                        us_cnt    <= us_restart;
                    end
                end

                ST_START: begin
                    if (us_cnt >= START_LIM) begin
                        drive_low <= 1'b0;
                        state     <= ST_WAIT;
                        us_cnt    <= us_restart;
                    end
                end

                ST_CHECK: begin
                    state <= ST_IDLE;
                    if (frame_ok) begin
                        humid <= frame_byte(shift_reg, BYTE_HUM_INT);
                        temp  <= frame_byte(shift_reg, BYTE_TEMP_INT);
                        done  <= 1'b1;
                    end else begin
                        error <= 1'b1;
                    end
                end

                // Wait-for-edge states share the restart and timeout handling.
                default: begin
                    if (edge_hit) begin
                        us_cnt <= us_restart;
                        case (state)
                            ST_WAIT:   state <= ST_SYNC_L;
                            ST_SYNC_L: state <= ST_SYNC_H;
                            ST_SYNC_H: state <= ST_DATA_L;
                            ST_DATA_L: state <= ST_DATA_H;
                            default: begin
                                shift_reg <= {shift_reg[FRAME_W-2:0], bit_val};
                                bit_cnt   <= bit_cnt + 6'd1;
                                state     <= (bit_cnt == LAST_BIT) ? ST_CHECK : ST_DATA_L;
                            end
                        endcase
                    end else if (us_cnt >= TIMEOUT_LIM) begin
                        error <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_controller.sv
// tb/tb_dht11_controller.sv - directed bench with sensor model and output scoreboard
module tb_dht11_controller;

    localparam int SYS_CLK_HZ = 2_000_000;
    localparam int DIV        = SYS_CLK_HZ / 1_000_000;
    localparam int START_US   = 100;
    localparam int TIMEOUT_US = 100;
    localparam int BIT1_US    = 40;
`ifdef DHT11_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sens_low = 1'b0;
    wire        dht_io;
    logic [7:0] humid, temp;
    logic       done, busy, error;

    pullup (dht_io);
    assign dht_io = sens_low ? 1'b0 : 1'bz;

    dht11_controller #(
        .SYS_CLK_HZ (SYS_CLK_HZ),
        .START_US   (START_US),
        .TIMEOUT_US (TIMEOUT_US),
        .BIT1_US    (BIT1_US)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .dht_io (dht_io),
        .humid  (humid),
        .temp   (temp),
        .done   (done),
        .busy   (busy),
        .error  (error)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         done_cnt = 0;
    logic [7:0] model_h = 8'h00, model_t = 8'h00;
    logic [7:0] pend_h = 8'h00, pend_t = 8'h00;
    bit         pend_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected result of a complete frame, from the byte rules alone.
    task automatic model_frame(input logic [39:0] f);
        int sum;
        sum = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        pend_done = !CHK_EN || ((sum % 256) == int'(f[7:0]));
        pend_h    = f[39:32];
        pend_t    = f[23:16];
    endtask

    // Scoreboard: every done must be expected; outputs must track the model.
    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (done) begin
                done_cnt++;
                if (!pend_done) begin
                    miscompares++;
                    $display("FAIL done_unexpected: got done=1, expected done=0");
                end else begin
                    model_h   = pend_h;
                    model_t   = pend_t;
                    pend_done = 1'b0;
                end
            end
            if (humid !== model_h || temp !== model_t) begin
                miscompares++;
                $display("FAIL outputs_vs_model: got humid=%02h temp=%02h, expected humid=%02h temp=%02h",
                         humid, temp, model_h, model_t);
                model_h = humid;
                model_t = temp;
            end
        end
    end

    task automatic us_wait(input int n);
        repeat (n * DIV) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("line_low_after_start", 32'(dht_io), 0);
        check("error_cleared_on_start", 32'(error), 0);
    endtask

    task automatic wait_release(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < (START_US + 20) * DIV; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (dht_io === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok || n < START_US * DIV - 4 || n > START_US * DIV + 4) begin
            miscompares++;
            $display("FAIL start_pulse_len: got %0d cycles (released=%0d), expected %0d +/-4",
                     n, ok, START_US * DIV);
        end
    endtask

    task automatic send_frame(input logic [39:0] f, input int hi0, input int hi1,
                              input int poke_bit, input int rst_bit);
        us_wait(30);
        sens_low = 1'b1; us_wait(80);
        sens_low = 1'b0; us_wait(80);
        for (int i = 0; i < 40; i++) begin
            if (i == rst_bit) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                model_h   = 8'h00;
                model_t   = 8'h00;
                pend_done = 1'b0;
                rst = 1'b0;
                check("rst_humid", 32'(humid), 0);
                check("rst_temp", 32'(temp), 0);
                check("rst_done", 32'(done), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_error", 32'(error), 0);
                check("rst_line_released", 32'(dht_io), 1);
                return;
            end
            sens_low = 1'b1;
            if (i == poke_bit) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                check("busy_during_poke", 32'(busy), 1);
            end
            us_wait(50);
            sens_low = 1'b0;
            us_wait(f[39-i] ? hi1 : hi0);
        end
        sens_low = 1'b1;
        us_wait(50);
        sens_low = 1'b0;
    endtask

    task automatic do_read(input logic [39:0] f, input int hi0, input int hi1,
                           input int poke_bit, input int rst_bit);
        bit ok;
        model_frame(f);
        do_start();
        wait_release(ok);
        if (ok) send_frame(f, hi0, hi1, poke_bit, rst_bit);
        us_wait(10);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got no completion, expected finish within 95000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int k;
        bit ok;

        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_humid", 32'(humid), 0);
        check("reset_temp", 32'(temp), 0);
        check("reset_done", 32'(done), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_error", 32'(error), 0);
        check("reset_line_released", 32'(dht_io), 1);

        // Nominal frame: hum 55.0, temp 24.0.
        d0 = done_cnt;
        do_read(40'h37_00_18_00_4F, 27, 70, -1, -1);
        check("s1_done_count", 32'(done_cnt - d0), 1);
        check("s1_humid", 32'(humid), 32'h37);
        check("s1_temp", 32'(temp), 32'h18);
        check("s1_error", 32'(error), 0);
        check("s1_busy", 32'(busy), 0);

        // No sensor response.
        d0 = done_cnt;
        do_start();
        wait_release(ok);
        if (ok) begin
            k = 0;
            while (error !== 1'b1 && k < 3 * TIMEOUT_US * DIV) begin
                @(posedge clk);
                #1;
                k++;
            end
            vectors++;
            if (k < TIMEOUT_US * DIV - 4 || k > TIMEOUT_US * DIV + 4) begin
                miscompares++;
                $display("FAIL timeout_latency: got %0d cycles, expected %0d +/-4",
                         k, TIMEOUT_US * DIV);
            end
        end
        check("s2_error", 32'(error), 1);
        check("s2_busy", 32'(busy), 0);
        check("s2_humid_held", 32'(humid), 32'h37);
        check("s2_temp_held", 32'(temp), 32'h18);
        check("s2_done_count", 32'(done_cnt - d0), 0);

        // start poked mid-frame must be ignored.
        d0 = done_cnt;
        do_read(40'h2A_05_11_03_43, 27, 70, 10, -1);
        check("s3_done_count", 32'(done_cnt - d0), 1);
        check("s3_humid", 32'(humid), 32'h2A);
        check("s3_temp", 32'(temp), 32'h11);
        check("s3_error", 32'(error), 0);

        // Checksum byte off by one.
        d0 = done_cnt;
        do_read(40'h37_00_18_00_50, 27, 70, -1, -1);
        check("s4_done_count", 32'(done_cnt - d0), CHK_EN ? 0 : 1);
        check("s4_error", 32'(error), CHK_EN ? 1 : 0);
        check("s4_humid", 32'(humid), CHK_EN ? 32'h2A : 32'h37);
        check("s4_temp", 32'(temp), CHK_EN ? 32'h11 : 32'h18);

        // Reset at bit 20.
        d0 = done_cnt;
        do_read(40'h37_00_18_00_4F, 27, 70, -1, 20);
        check("s5_done_count", 32'(done_cnt - d0), 0);
        check("s5_busy", 32'(busy), 0);

        // Clean read after reset, with high phases at 39/41 us around the threshold.
        d0 = done_cnt;
        do_read(40'hA5_00_3C_00_E1, 39, 41, -1, -1);
        check("s6_done_count", 32'(done_cnt - d0), 1);
        check("s6_humid", 32'(humid), 32'hA5);
        check("s6_temp", 32'(temp), 32'h3C);
        check("s6_error", 32'(error), 0);
        check("s6_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
